// File: rtl/rv_imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rv_imm_pkg                                                      |
// | Purpose  : Shared types for the RV32I/RV64I immediate-generation stage:    |
// |            format codes, base opcodes, the stored pipeline entry, and a    |
// |            helper that classifies an opcode/funct3 pair into a format.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package rv_imm_pkg;

    // Entries are stored at the widest legal XLEN. For a 32-bit build the
    // upper halves are tied to zero and optimise away.
    localparam int c_xlen_max = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_ILL = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // funct3 codes of the immediate shifts (SLLI and SRLI/SRAI).
    localparam logic [2:0] c_f3_sll = 3'b001;
    localparam logic [2:0] c_f3_srx = 3'b101;

    typedef struct packed {
        logic [c_xlen_max-1:0] imm;
        logic [c_xlen_max-1:0] target;
        logic [c_xlen_max-1:0] pc;
        imm_fmt_e              fmt;
        logic                  illegal;
    } imm_entry_t;

    function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode,
                                            input logic [2:0] funct3);
        imm_fmt_e fmt;
        case (opcode)
            OPC_OP_IMM: begin
                if ((funct3 == c_f3_sll) || (funct3 == c_f3_srx)) begin
                    fmt = FMT_SH;
                end else begin
                    fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: fmt = FMT_I;
            OPC_STORE:                                 fmt = FMT_S;
            OPC_BRANCH:                                fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
            OPC_JAL:                                   fmt = FMT_J;
            OPC_OP:                                    fmt = FMT_R;
            default:                                   fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_skid_buffer                                                 |
// | Purpose  : Generic two-entry valid/ready buffer (main + skid). in_ready is |
// |            a flop, so there is no combinational path from out_ready back   |
// |            to in_ready. Strict FIFO order; flush empties both entries.     |
// | Ports    : clk, rst, flush; in_valid/in_ready/in_data upstream;            |
// |            out_valid/out_ready/out_data downstream (out_data = main).      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module imm_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  wire logic             out_ready,
    output logic [WIDTH-1:0]      out_data
);

    logic             r_main_valid_q;
    logic [WIDTH-1:0] r_main_data_q;
    logic             r_skid_valid_q;
    logic [WIDTH-1:0] r_skid_data_q;
    logic             r_in_ready_q;

    logic             w_main_valid_d;
    logic [WIDTH-1:0] w_main_data_d;
    logic             w_skid_valid_d;
    logic [WIDTH-1:0] w_skid_data_d;
    logic             w_in_ready_d;
    logic             w_accept;
    logic             w_retire;

    // Acceptance uses the registered ready, which is only high when the skid
    // slot is empty, so an accepted word always has somewhere to go.
    assign w_accept = in_valid && r_in_ready_q;
    assign w_retire = r_main_valid_q && out_ready;

    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_data_d  = r_main_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_data_d  = r_skid_data_q;

        if (flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_main_valid_q) begin
            // Empty: the skid slot is never occupied while main is empty.
            if (w_accept) begin
                w_main_valid_d = 1'b1;
                w_main_data_d  = in_data;
            end
        end else if (!r_skid_valid_q) begin
            // One entry held.
            if (w_retire && w_accept) begin
                w_main_data_d = in_data;
            end else if (w_retire) begin
                w_main_valid_d = 1'b0;
            end else if (w_accept) begin
                w_skid_valid_d = 1'b1;
                w_skid_data_d  = in_data;
            end
        end else if (w_retire) begin
            // Full: the older skid entry moves up into main.
            w_main_data_d  = r_skid_data_q;
            w_skid_valid_d = 1'b0;
        end

        w_in_ready_d = !w_skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_data_q  <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_data_q  <= '0;
            r_in_ready_q   <= 1'b1;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_data_q  <= w_main_data_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_data_q  <= w_skid_data_d;
            r_in_ready_q   <= w_in_ready_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_main_valid_q;
    assign out_data  = r_main_data_q;

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_gen_stage                                                   |
// | Purpose  : Registered, handshaked immediate generator between fetch and    |
// |            execute. Decodes every RV32I immediate format, sign-extends to  |
// |            XLEN, computes pc+imm and buffers the result in a 2-entry skid. |
// | Ports    : clk, rst (sync, active-high), flush;                            |
// |            in_valid/in_ready/in_instr/in_pc upstream;                      |
// |            out_valid/out_ready/out_imm/out_target/out_pc/out_fmt/          |
// |            out_illegal downstream.                                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module imm_gen_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32   // 32 or 64
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            flush,
    input  wire logic            in_valid,
    output logic                 in_ready,
    input  wire logic [31:0]     in_instr,
    input  wire logic [XLEN-1:0] in_pc,
    output logic                 out_valid,
    input  wire logic            out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_target,
    output logic [XLEN-1:0]      out_pc,
    output logic [2:0]           out_fmt,
    output logic                 out_illegal
);

    imm_fmt_e        w_fmt;
    logic [31:0]     w_shamt32;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    imm_entry_t      w_in_entry;
    imm_entry_t      w_out_entry;

    // RV64 shifts carry a 6-bit shift amount; RV32 only 5. Bit 30 (the
    // arithmetic-shift select) is never part of the immediate.
    generate
        if (XLEN == 64) begin : g_shamt_rv64
            assign w_shamt32 = {26'b0, in_instr[25:20]};
        end else begin : g_shamt_rv32
            assign w_shamt32 = {27'b0, in_instr[24:20]};
        end
    endgenerate

    // All formats fit in 32 bits; extension to XLEN is a single sign-extend
    // below. The shift amount is zero in its top bit, so it zero-extends.
    always_comb begin
        w_fmt   = decode_fmt(in_instr[6:0], in_instr[14:12]);
        w_imm32 = '0;
        case (w_fmt)
            FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_SH:  w_imm32 = w_shamt32;
            FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm    = XLEN'($signed(w_imm32));
    // Computed for every format; for JALR the consumer ignores it.
    assign w_target = in_pc + w_imm;

    always_comb begin
        w_in_entry                    = '0;
        w_in_entry.imm[XLEN-1:0]      = w_imm;
        w_in_entry.target[XLEN-1:0]   = w_target;
        w_in_entry.pc[XLEN-1:0]       = in_pc;
        w_in_entry.fmt                = w_fmt;
        w_in_entry.illegal            = (w_fmt == FMT_ILL);
    end

    imm_skid_buffer #(
        .WIDTH ($bits(imm_entry_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_entry)
    );

    assign out_imm     = w_out_entry.imm[XLEN-1:0];
    assign out_target  = w_out_entry.target[XLEN-1:0];
    assign out_pc      = w_out_entry.pc[XLEN-1:0];
    assign out_fmt     = w_out_entry.fmt;
    assign out_illegal = w_out_entry.illegal;

    // Narrow builds leave the upper halves of the stored entry unread.
    generate
        if (XLEN < c_xlen_max) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^{w_out_entry.imm[c_xlen_max-1:XLEN],
                                   w_out_entry.target[c_xlen_max-1:XLEN],
                                   w_out_entry.pc[c_xlen_max-1:XLEN]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_imm_gen_stage                                                |
// | Purpose  : Self-checking bench for imm_gen_stage (XLEN=32): directed test  |
// |            vectors, backpressure, flush and reset, then randomized traffic |
// |            checked by a queue-based scoreboard and reference model.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_imm_gen_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_pc      (out_pc),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Interpret an n-bit two's-complement field as a signed number.
    function automatic longint sx(input longint x, input int n);
        longint half;
        half = longint'(1) << (n - 1);
        return (x >= half) ? x - (half * 2) : x;
    endfunction

    // Reference model: immediates assembled as weighted bit sums.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t   e;
        longint v;
        longint t;
        logic [6:0] opc;
        logic [2:0] f3;
        opc = ins[6:0];
        f3  = ins[14:12];
        v   = 0;
        e.ill = 1'b0;
        case (opc)
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.fmt = 3'd2;
                    v = longint'(ins[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    v = sx(longint'(ins[31:20]), 12);
                end
            end
            7'h03, 7'h67, 7'h73, 7'h0F: begin
                e.fmt = 3'd1;
                v = sx(longint'(ins[31:20]), 12);
            end
            7'h23: begin
                e.fmt = 3'd3;
                v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            end
            7'h63: begin
                e.fmt = 3'd4;
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                       longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd5;
                v = sx(longint'(ins[31:12]) * 4096, 32);
            end
            7'h6F: begin
                e.fmt = 3'd6;
                v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                       longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            end
            7'h33: e.fmt = 3'd0;
            default: begin
                e.fmt = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        t = longint'(pc) + v;
        e.imm    = v[31:0];
        e.target = t[31:0];
        e.pc     = pc;
        return e;
    endfunction

    // Scoreboard monitor: a retire at the coming edge pops, an accept pushes.
    exp_t        mon_e;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_imm;
    logic [31:0] prev_pc;
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stable_valid", out_valid, 1);
            chk("stable_imm", out_imm, prev_imm);
            chk("stable_pc", out_pc, prev_pc);
        end
        prev_stall = out_valid && !out_ready && !rst && !flush;
        prev_imm   = out_imm;
        prev_pc    = out_pc;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got_pc=%0h exp=none", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_imm", out_imm, mon_e.imm);
                    chk("sb_target", out_target, mon_e.target);
                    chk("sb_pc", out_pc, mon_e.pc);
                    chk("sb_fmt", out_fmt, mon_e.fmt);
                    chk("sb_illegal", out_illegal, mon_e.ill);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=no_accept exp=accept pc=%0h", pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill, input logic [31:0] target);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_imm"}, out_imm, imm);
        chk({name, "_fmt"}, out_fmt, fmt);
        chk({name, "_illegal"}, out_illegal, ill);
        chk({name, "_target"}, out_target, target);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        int          k;
        opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) r[6:0] = opcs[k];
        return r;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(posedge clk); #1;      // in_valid ignored during reset
        in_valid = 1'b0;
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);

        // Directed vectors, one per cycle with no stall.
        send(32'hFFF00093, 32'h0);
        chk_out("addi", 32'hFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF);
        send(32'hFE112E23, 32'h40);
        chk_out("sw", 32'hFFFFFFFC, 3'd3, 1'b0, 32'h3C);
        send(32'hFE000CE3, 32'h100);
        chk_out("beq", 32'hFFFFFFF8, 3'd4, 1'b0, 32'hF8);
        send(32'h123450B7, 32'h10);
        chk_out("lui", 32'h12345000, 3'd5, 1'b0, 32'h12345010);
        send(32'h0010006F, 32'h20);
        chk_out("jal", 32'h800, 3'd6, 1'b0, 32'h820);
        send(32'h4030D093, 32'h30);
        chk_out("srai", 32'h3, 3'd2, 1'b0, 32'h33);
        send(32'h0000007F, 32'h300);
        chk_out("illegal", 32'h0, 3'd7, 1'b1, 32'h300);
        @(posedge clk); #1;
        chk("idle_valid", out_valid, 0);

        // Backpressure: two accepted, then ready drops.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        chk("bp_ready0", in_ready, 1);
        @(posedge clk); #1;
        in_instr = 32'h00200113; in_pc = 32'h204;
        chk("bp_ready1", in_ready, 1);
        @(posedge clk); #1;
        in_instr = 32'h00300193; in_pc = 32'h208;
        chk("bp_ready_drop", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second_pc", out_pc, 32'h204);
        chk("bp_ready_back", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_third_pc", out_pc, 32'h208);
        chk("bp_third_imm", out_imm, 32'h3);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Flush with two entries buffered; the same-cycle accept is discarded.
        out_ready = 1'b0;
        send(32'h00400213, 32'h500);
        send(32'h00500293, 32'h504);
        chk("fl_pre_valid", out_valid, 1);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h508;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("fl_after_valid", out_valid, 0);

        // Reset mid-stream.
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h600);
        send(32'h0010006F, 32'h604);
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h608;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_imm", out_imm, 0);
        chk("mrst_target", out_target, 0);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_fmt", out_fmt, 0);
        chk("mrst_illegal", out_illegal, 0);

        // Randomized traffic with random stalls and occasional flushes.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom & 32'hFFFFFFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, handshaked immediate-generation stage between fetch and execute. Accepts one instruction word plus its PC per cycle and decodes every RV32I immediate format (I, S, B, U, J, plus shift-amount). Emits the sign-extended XLEN-bit immediate, the format code, an illegal-opcode flag, and the PC-relative target pc+imm. A two-entry skid buffer decouples upstream and downstream stalls without a combinational ready path.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  instruction word and PC valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_pc  in  XLEN  address of in_instr
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_imm  out  XLEN  decoded immediate
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
- out_pc  out  XLEN  PC passed through
- out_fmt  out  3  imm_fmt_e format code
- out_illegal  out  1  opcode not recognised

## Operation
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Decode on instr[6:0]:
  - I: 0010011 (except shifts), 0000011, 1100111, 1110011, 0001111; imm = sext(instr[31:20]).
  - SH: 0010011 with funct3 001/101; imm = zext(instr[24:20]) for XLEN=32, zext(instr[25:20]) for XLEN=64; bit 30 is ignored.
  - S: 0100011; imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111, 0010111; imm = sext({instr[31:12], 12'b0}).
  - J: 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0110011; imm = 0, out_fmt = FMT_R.
  - Any other opcode: out_fmt = FMT_ILL, imm = 0, out_illegal = 1. The entry still flows through the stage; it is not dropped.
- Target:
  - out_target = pc + imm, computed for every format, wraps with no overflow flag.
  - For JALR the value is meaningless; the consumer selects on out_fmt.
- Buffer:
  - Two entries, main and skid. Accept when in_valid && in_ready. Retire when out_valid && out_ready.
  - Strict FIFO order.
  - in_ready is the registered value of !(skid occupied).
- Precedence per cycle: rst > flush > accept/retire.
  - flush empties both entries. An accept in the same cycle is discarded.
  - After flush, in_ready = 1 next cycle.

## Timing
- Reset values: out_valid=0, in_ready=1 from the first cycle after rst deasserts. All data outputs are 0.
- in_valid is ignored while rst is high.
- Latency: an accepted word appears on the outputs the next cycle.
- Throughput: 1/cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, all out_* stay stable.
- Backpressure: with out_ready low, two more words are accepted (main + skid), then in_ready drops the following cycle.
- Simultaneous accept and retire with one entry held: occupancy stays 1, with no bubble.
- Full buffer: when out_ready rises, the skid entry moves to main and in_ready returns to 1 the next cycle.
- Reset or flush mid-stall: all entries are lost and out_valid=0 next cycle.

## Structure
- Package rv_imm_pkg:
  - imm_fmt_e enum: FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL.
  - Opcode localparams: OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP.
  - Packed struct imm_entry_t holding {imm, target, pc, fmt, illegal}.
- Decode and the target adder are combinational on the input side. Only imm_entry_t is stored.
- One sub-module: imm_skid_buffer, a generic two-entry valid/ready buffer parametrised by payload type/width.

## Test plan
- I-type: 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> next cycle out_imm=0xFFFFFFFF, FMT_I, out_illegal=0.
- S-type: 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, FMT_S.
- B-type: 0xFE000CE3, pc=0x100 -> out_imm=0xFFFFFFF8, out_target=0xF8.
- U, J and SH in sequence, one per cycle: 0x123450B7 -> 0x12345000, FMT_U; then 0x0010006F -> 0x800, FMT_J; then 0x4030D093 (srai) -> 3, FMT_SH.
- Backpressure:
  - Hold out_ready=0 and present 3 words -> 2 accepted, then in_ready=0.
  - Raise out_ready -> outputs appear in order and the third word is accepted.
  - No loss or duplication.
- Illegal opcode, flush and reset:
  - Word 0x0000007F -> out_illegal=1, imm=0.
  - flush with 2 entries buffered -> out_valid=0 next cycle.
  - rst asserted mid-stream -> all outputs read their reset values.
